// File: rtl/actel_capture_fifo.sv
// Capture stage for registered logic-cell outputs: optional change-only
// sampling, cycle stamping, and a first-word-fall-through drain FIFO.
module actel_capture_fifo #(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int TW    = 8
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic [N-1:0]           in_data,
    input  logic                   in_en,
    input  logic                   chg_only,
    input  logic                   rd_ready,
    input  logic                   clr_ovf,
    output logic                   rd_valid,
    output logic [N-1:0]           rd_data,
    output logic [TW-1:0]          rd_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] stamp;
    logic [N-1:0]  last_data;
    logic          first_flag;

    logic [N-1:0]  mem_data  [DEPTH];
    logic [TW-1:0] mem_stamp [DEPTH];

    logic qual;
    logic pop;
    logic push;
    logic drop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign rd_valid = ~empty;

    // pop depends only on registered state and rd_ready; it never feeds rd_valid
    assign pop  = rd_valid & rd_ready;
    assign qual = in_en & (~chg_only | first_flag | (in_data != last_data));
    assign push = qual & (~full | pop);
    assign drop = qual & full & ~pop;

    assign rd_data  = rd_valid ? mem_data[rd_ptr]  : '0;
    assign rd_stamp = rd_valid ? mem_stamp[rd_ptr] : '0;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stamp      <= '0;
            overflow   <= 1'b0;
            first_flag <= 1'b1;
            last_data  <= '0;
        end else begin
            stamp <= stamp + 1'b1;
            if (qual) begin
                last_data  <= in_data;
                first_flag <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is left uninitialised; empty masks whatever it holds.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr]  <= in_data;
            mem_stamp[wr_ptr] <= stamp;
        end
    end

endmodule

// File: tb/tb_actel_capture_fifo.sv
// Directed bench for actel_capture_fifo: vector table for the basic
// capture/drain path plus hand sequences for the multi-cycle corners.
module tb_actel_capture_fifo;

    logic       CLK;
    logic       CLR;
    logic [3:0] in_data;
    logic       in_en;
    logic       chg_only;
    logic       rd_ready;
    logic       clr_ovf;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [7:0] rd_stamp;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    actel_capture_fifo #(.N(4), .DEPTH(8), .TW(8)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .in_data  (in_data),
        .in_en    (in_en),
        .chg_only (chg_only),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_stamp (rd_stamp),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       en;
        logic [3:0] d;
        logic       chg;
        logic       rdy;
        logic       co;
        logic       v;
        logic [3:0] rd;
        logic [7:0] st;
        logic [3:0] cnt;
        logic       f;
        logic       e;
        logic       o;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mkv(
        logic en, logic [3:0] d, logic chg, logic rdy, logic co,
        logic v, logic [3:0] rd, logic [7:0] st, logic [3:0] cnt,
        logic f, logic e, logic o);
        vec_t t;
        t.en = en;  t.d = d;   t.chg = chg; t.rdy = rdy;
        t.co = co;  t.v = v;   t.rd = rd;   t.st = st;
        t.cnt = cnt; t.f = f;  t.e = e;     t.o = o;
        return t;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic en, logic [3:0] d, logic chg,
                         logic rdy, logic co);
        in_en    = en;
        in_data  = d;
        chg_only = chg;
        rd_ready = rdy;
        clr_ovf  = co;
        step();
    endtask

    task automatic state(string name, logic v, logic [3:0] d,
                         logic [3:0] cnt, logic o);
        chk({name, ".valid"}, 32'(rd_valid), 32'(v));
        if (v) chk({name, ".data"}, 32'(rd_data), 32'(d));
        chk({name, ".count"}, 32'(count), 32'(cnt));
        chk({name, ".full"}, 32'(full), 32'(cnt == 4'd8));
        chk({name, ".empty"}, 32'(empty), 32'(cnt == 4'd0));
        chk({name, ".ovf"}, 32'(overflow), 32'(o));
    endtask

    task automatic pop_expect(string name, logic [3:0] d);
        in_en    = 1'b0;
        rd_ready = 1'b1;
        clr_ovf  = 1'b0;
        chk({name, ".valid"}, 32'(rd_valid), 32'd1);
        chk({name, ".data"}, 32'(rd_data), 32'(d));
        step();
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        in_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        CLR = 1'b0;
        step();
        step();
        CLR = 1'b1;
    endtask

    initial begin
        CLR = 1'b0;
        in_data = '0; in_en = 1'b0; chg_only = 1'b0;
        rd_ready = 1'b0; clr_ovf = 1'b0;

        for (int i = 0; i < 10; i++)
            tbl[i] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mkv(1, 5, 0, 0, 0, 1, 5, 10, 1, 0, 0, 0);
        tbl[11] = mkv(1, 5, 0, 0, 0, 1, 5, 10, 2, 0, 0, 0);
        tbl[12] = mkv(1, 9, 0, 0, 0, 1, 5, 10, 3, 0, 0, 0);
        tbl[13] = mkv(0, 0, 0, 1, 0, 1, 5, 11, 2, 0, 0, 0);
        tbl[14] = mkv(0, 0, 0, 1, 0, 1, 9, 12, 1, 0, 0, 0);
        tbl[15] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[16] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[17] = mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        step();
        step();
        state("reset", 0, 0, 0, 0);
        chk("reset.data0", 32'(rd_data), 32'd0);
        chk("reset.stamp0", 32'(rd_stamp), 32'd0);
        CLR = 1'b1;

        // row i is presented in the cycle whose stamp value is i
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].d, tbl[i].chg, tbl[i].rdy, tbl[i].co);
            chk($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d.data", i), 32'(rd_data), 32'(tbl[i].rd));
            chk($sformatf("vec%0d.stamp", i), 32'(rd_stamp), 32'(tbl[i].st));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(tbl[i].f));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(tbl[i].o));
        end

        // change-only capture from a fresh reset
        do_reset();
        drive(1, 3, 1, 0, 0);
        drive(1, 3, 1, 0, 0);
        drive(1, 3, 1, 0, 0);
        drive(1, 7, 1, 0, 0);
        drive(1, 7, 1, 0, 0);
        drive(1, 3, 1, 0, 0);
        state("chg", 1, 3, 3, 0);
        pop_expect("chg.pop0", 3);
        pop_expect("chg.pop1", 7);
        pop_expect("chg.pop2", 3);
        state("chg.drained", 0, 0, 0, 0);

        // fill, drop, clear, drop against clear
        for (int i = 1; i <= 8; i++) drive(1, 4'(i), 0, 0, 0);
        state("fill8", 1, 1, 8, 0);
        drive(1, 9, 0, 0, 0);
        state("drop", 1, 1, 8, 1);
        drive(0, 0, 0, 0, 1);
        state("clrovf", 1, 1, 8, 0);
        drive(1, 10, 0, 0, 1);
        state("drop_vs_clr", 1, 1, 8, 1);
        drive(0, 0, 0, 0, 1);
        state("clrovf2", 1, 1, 8, 0);

        // full with same-cycle pop accepts the new sample
        drive(1, 11, 0, 1, 0);
        state("full_pop", 1, 2, 8, 0);
        for (int i = 2; i <= 8; i++)
            pop_expect($sformatf("fp.pop%0d", i), 4'(i));
        state("fp.tail", 1, 11, 1, 0);
        pop_expect("fp.pop11", 11);
        state("fp.drained", 0, 0, 0, 0);

        // async reset mid-stream
        for (int i = 1; i <= 9; i++) drive(1, 4'(i), 0, 0, 0);
        pop_expect("ar.pop1", 1);
        pop_expect("ar.pop2", 2);
        pop_expect("ar.pop3", 3);
        state("ar.pre", 1, 4, 5, 1);
        #2;
        CLR = 1'b0;
        #1;
        state("ar.async", 0, 0, 0, 0);
        chk("ar.data0", 32'(rd_data), 32'd0);
        step();
        CLR = 1'b1;
        drive(1, 0, 1, 0, 0);
        state("ar.first", 1, 0, 1, 0);
        chk("ar.stamp", 32'(rd_stamp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/actel_capture_fifo.md
Name: actel_capture_fifo

Overview:
Downstream capture stage for the registered logic-module cells (S1/S2 style; N-bit registered output, CLK-clocked). Samples the cell output, optionally only on change. Tags each sample with a free-running cycle stamp. Buffers samples in a first-word-fall-through FIFO so the software side can drain them over a valid/ready handshake at its own pace.

Parameters:
N, 4, width of captured data (matches the upstream cell's N)
DEPTH, 8, FIFO entries; power of two, >= 2
TW, 8, cycle-stamp width

Ports:
CLK  input  1  clock, all state updates on rising edge
CLR  input  1  asynchronous, active-low reset (CLR=0 resets immediately, independent of CLK)
in_data  input  N  registered output of the upstream logic cell
in_en  input  1  sample enable; in_data considered only when 1
chg_only  input  1  1 = capture only when in_data differs from last captured value; 0 = capture every enabled cycle
rd_ready  input  1  consumer accepts head entry this cycle
clr_ovf  input  1  synchronous clear of sticky overflow flag
rd_valid  output  1  head entry present (FIFO not empty)
rd_data  output  N  head entry data
rd_stamp  output  TW  head entry cycle stamp
count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a qualified sample was dropped

Behaviour:
- Reset (CLR=0):
  - Pointers, count, stamp counter and overflow go to 0.
  - rd_valid=0, empty=1, full=0.
  - rd_data/rd_stamp read 0.
  - first_flag=1 and last_data=0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all entries immediately.
- Stamp counter:
  - Increments by 1 every cycle out of reset.
  - Wraps modulo 2^TW (2^TW-1 -> 0).
  - A captured entry stores the counter value of the cycle in which the sample is presented.
- Qualification:
  - qual = in_en & (~chg_only | first_flag | (in_data != last_data)).
  - On every qual cycle, last_data<=in_data and first_flag<=0, whether or not the push succeeds.
  - A dropped sample therefore still updates last_data.
- Push: occurs when qual & (~full | pop).
  - When full, a same-cycle pop frees the slot, so the push is accepted.
- Drop: qual & full & ~pop.
  - The sample is discarded, overflow<=1.
  - Storage, pointers and count are unchanged.
- Pop: pop = rd_valid & rd_ready.
  - rd_ready while empty has no effect.
- Write/read pointers: $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
- count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- First-word fall-through:
  - rd_data/rd_stamp are driven combinationally from storage[rd_ptr]; valid whenever rd_valid=1.
  - Latency from accepted push to rd_valid=1 is 1 cycle.
  - A push and pop in the same cycle on an empty FIFO is impossible: rd_valid=0 means pop=0.
- rd_valid = ~empty; full/empty/rd_valid are derived from count (no extra register lag).
- overflow:
  - Set on drop, cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins (overflow stays 1).
- No combinational path from rd_ready to rd_valid or rd_data.

Test Plan:
- Reset/idle: CLR=0 for 2 cycles then 1, in_en=0 -> rd_valid=0, empty=1, count=0, overflow=0; stamp counter 0 then increments every cycle.
- Every-cycle capture: chg_only=0, in_en=1 for 3 cycles with in_data=5,5,9 at stamps 10,11,12; rd_ready=0 -> count=3. Then rd_ready=1 -> pops (5,10), (5,11), (9,12) on consecutive cycles, then empty=1.
- Change-only: chg_only=1, in_data sequence 3,3,3,7,7,3 with in_en=1 -> exactly 3 entries: 3 (first sample), 7, 3.
- Full/overflow (DEPTH=8): push 9 distinct values, rd_ready=0 -> count=8, full=1, 9th value absent, overflow=1. Pulse clr_ovf -> overflow=0. Drop coinciding with clr_ovf -> overflow stays 1.
- Full with simultaneous pop: count=8, qual and rd_ready both 1 -> head popped, new entry accepted, count stays 8, overflow unchanged; new value appears after 7 further pops.
- Async reset mid-stream: count=5, assert CLR low between clock edges -> rd_valid, count, overflow go to 0 before the next edge; after release, first enabled sample is captured even with chg_only=1 and in_data=0.
